// File: rtl/maxpool_22_s2_pkg.sv
// Shared float/pooling definitions for the maxpool_22_s2 stage and its comparator.
// Fused ReLU is selected at build time with macro MAXPOOL_RELU_EN.
package maxpool_22_s2_pkg;

    localparam int DATA_W      = 32;
    localparam int D_DEFAULT   = 149;
    localparam int FP_SIGN_BIT = DATA_W - 1;
    localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_SKIP = 2'd2
    } state_t;

    // Monotonic unsigned key: positives above negatives, negatives reversed.
    function automatic logic [DATA_W-1:0] fp_key(input logic [DATA_W-1:0] x);
        return x[FP_SIGN_BIT] ? ~x : {1'b1, x[FP_SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/maxpool_22_s2_fp32_max.sv
// Combinational ordered float maximum; operand a wins ties, and +0/-0 tie.
module fp32_max
    import maxpool_22_s2_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] max
);

    logic [DATA_W-1:0] w_key_a;
    logic [DATA_W-1:0] w_key_b;
    logic              w_both_zero;

    assign w_key_a     = fp_key(a);
    assign w_key_b     = fp_key(b);
    assign w_both_zero = (a[FP_SIGN_BIT-1:0] == '0) && (b[FP_SIGN_BIT-1:0] == '0);
    assign max         = (!w_both_zero && (w_key_b > w_key_a)) ? b : a;

endmodule

// File: rtl/maxpool_22_s2.sv
// 2x2 stride-2 float max pooling over a raster DxD stream, stalling on valid_in=0.
// Build option: MAXPOOL_RELU_EN zeroes negative inputs before pooling.
module maxpool_22_s2
    import maxpool_22_s2_pkg::*;
#(
    parameter int D          = D_DEFAULT,
    parameter int data_width = DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [data_width-1:0] pxl_in,
    output logic [data_width-1:0] pxl_out,
    output logic                  valid_out
);

    localparam int CW = $clog2(D);
    localparam int NW = D / 2;
    localparam int AW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST     = CW'(D - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(D - 2);
    localparam bit D_ODD = (D % 2) == 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_row;
    logic [data_width-1:0] r_h;
    logic [data_width-1:0] r_pxl_out;
    logic                  r_valid_out;
    logic [data_width-1:0] r_line [NW];

    logic [data_width-1:0] w_px;
    logic [data_width-1:0] w_hmax;
    logic [data_width-1:0] w_vmax;
    logic [data_width-1:0] w_above;
    logic [AW-1:0]         w_idx;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_active;

`ifdef MAXPOOL_RELU_EN
    assign w_px = pxl_in[data_width-1] ? data_width'(FP_ZERO) : pxl_in;
`else
    assign w_px = pxl_in;
`endif

    assign w_col_last = (r_col == LAST);
    assign w_row_last = (r_row == LAST);
    // Odd D: the trailing column has no partner and is consumed silently.
    assign w_active   = valid_in && !(D_ODD && w_col_last);
    assign w_idx      = r_col[AW:1];
    assign w_above    = r_line[w_idx];

    fp32_max u_hmax (
        .a   (r_h),
        .b   (w_px),
        .max (w_hmax)
    );

    fp32_max u_vmax (
        .a   (w_above),
        .b   (w_hmax),
        .max (w_vmax)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (valid_in && w_col_last) begin
            case (r_state)
                ST_FILL: w_state_nxt = ST_EMIT;
                ST_EMIT: w_state_nxt = (D_ODD && (r_row == PRE_LAST)) ? ST_SKIP : ST_FILL;
                ST_SKIP: w_state_nxt = ST_FILL;
                default: w_state_nxt = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid_in) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h         <= '0;
            r_pxl_out   <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (w_active) begin
                if (!r_col[0]) begin
                    r_h <= w_px;
                end else if (r_state == ST_EMIT) begin
                    r_pxl_out   <= w_vmax;
                    r_valid_out <= 1'b1;
                end
            end
        end
    end

    // Line buffer holds the upper-row horizontal maxima; never needs clearing.
    always_ff @(posedge clk) begin
        if (w_active && r_col[0] && (r_state == ST_FILL)) begin
            r_line[w_idx] <= w_hmax;
        end
    end

    assign pxl_out   = r_pxl_out;
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_maxpool_22_s2.sv
// Bench for maxpool_22_s2 at D=4, D=5 and D=149 against a real-valued window model.
module tb_maxpool_22_s2;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_v;
    logic [31:0] pxl_in;
    int          sel;
    logic        v4, v5, v149;
    logic [31:0] o4, o5, o149;
    logic        vo4, vo5, vo149;

    always #5 clk = ~clk;

    assign v4   = bus_v && (sel == 4);
    assign v5   = bus_v && (sel == 5);
    assign v149 = bus_v && (sel == 149);

    maxpool_22_s2 #(.D(4)) u_d4 (
        .clk(clk), .reset(reset), .valid_in(v4), .pxl_in(pxl_in),
        .pxl_out(o4), .valid_out(vo4)
    );
    maxpool_22_s2 #(.D(5)) u_d5 (
        .clk(clk), .reset(reset), .valid_in(v5), .pxl_in(pxl_in),
        .pxl_out(o5), .valid_out(vo5)
    );
    maxpool_22_s2 #(.D(149)) u_d149 (
        .clk(clk), .reset(reset), .valid_in(v149), .pxl_in(pxl_in),
        .pxl_out(o149), .valid_out(vo149)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_v[$];
    int          got_t[$];
    always @(negedge clk) begin
        if (vo4)   begin got_v.push_back(o4);   got_t.push_back(cyc); end
        if (vo5)   begin got_v.push_back(o5);   got_t.push_back(cyc); end
        if (vo149) begin got_v.push_back(o149); got_t.push_back(cyc); end
    end

    logic [31:0] exp_v[$];
    int          exp_t[$];
    logic [31:0] frm[];
    int          stamp[];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        int  e;
        real m;
        real v;
        e = int'(b[30:23]);
        m = real'(b[22:0]) / 8388608.0;
        if (e == 0) v = m * (2.0 ** (-126));
        else        v = (1.0 + m) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] b);
`ifdef MAXPOOL_RELU_EN
        return b[31] ? 32'h0 : b;
`else
        return b;
`endif
    endfunction

    function automatic logic [31:0] int2f(input int n);
        int          p;
        logic [31:0] m;
        p = 0;
        for (int k = 0; k < 31; k++) if ((n >> k) != 0) p = k;
        m = (32'(n) << (23 - p)) & 32'h007f_ffff;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_f(input logic [31:0] prev);
        int          k;
        logic [31:0] b;
        k = int'($urandom_range(0, 15));
        if (k == 0) return 32'h0000_0000;
        if (k == 1) return 32'h8000_0000;
        if (k < 4)  return prev;
        b = $urandom;
        if (b[30:23] == 8'hff) b[30] = 1'b0;
        return b;
    endfunction

    task automatic fill_ramp(input int d);
        frm = new[d * d];
        for (int i = 0; i < d * d; i++) frm[i] = int2f(i + 1);
    endtask

    task automatic fill_rand(input int d);
        frm = new[d * d];
        frm[0] = rnd_f(32'h3f80_0000);
        for (int i = 1; i < d * d; i++) frm[i] = rnd_f(frm[i-1]);
    endtask

    // Drives one frame (gap = percent chance of an idle cycle before each pixel)
    // and appends the expected window maxima and their arrival cycles.
    task automatic run_frame(input int d, input int id, input int gap);
        logic [31:0] best, cand;
        int          base;
        stamp = new[d * d];
        sel   = id;
        for (int i = 0; i < d * d; i++) begin
            while (int'($urandom_range(1, 100)) <= gap) begin
                @(negedge clk);
                bus_v  = 1'b0;
                pxl_in = $urandom;
            end
            @(negedge clk);
            bus_v    = 1'b1;
            pxl_in   = frm[i];
            stamp[i] = cyc;
        end
        @(negedge clk);
        bus_v = 1'b0;
        for (int r = 0; r < d / 2; r++) begin
            for (int c = 0; c < d / 2; c++) begin
                base = 2 * r * d + 2 * c;
                best = relu(frm[base]);
                for (int k = 1; k < 4; k++) begin
                    cand = relu(frm[base + (k / 2) * d + (k % 2)]);
                    if (f2r(cand) > f2r(best)) best = cand;
                end
                exp_v.push_back(best);
                exp_t.push_back(stamp[base + d + 1] + 1);
            end
        end
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_out(input string tag);
        int n;
        chk({tag, "_count"}, 32'(got_v.size()), 32'(exp_v.size()));
        n = (got_v.size() < exp_v.size()) ? got_v.size() : exp_v.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_val%0d", tag, i), got_v[i], exp_v[i]);
            chk($sformatf("%s_cyc%0d", tag, i), 32'(got_t[i]), 32'(exp_t[i]));
        end
        got_v.delete(); got_t.delete(); exp_v.delete(); exp_t.delete();
    endtask

    initial begin
        logic [31:0] last;
        reset  = 1'b0;
        bus_v  = 1'b0;
        pxl_in = 32'h0;
        sel    = 0;
        repeat (2) @(negedge clk);
        chk("rst_o4", o4, 32'h0);     chk("rst_vo4", 32'(vo4), 32'h0);
        chk("rst_o5", o5, 32'h0);     chk("rst_vo5", 32'(vo5), 32'h0);
        chk("rst_o149", o149, 32'h0); chk("rst_vo149", 32'(vo149), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // D=4 ramp, continuous
        fill_ramp(4);
        run_frame(4, 4, 0);
        drain();
        chk("ramp4_o0", got_v[0], 32'h40c0_0000);
        chk("ramp4_o1", got_v[1], 32'h4100_0000);
        chk("ramp4_o2", got_v[2], 32'h4160_0000);
        chk("ramp4_o3", got_v[3], 32'h4180_0000);
        check_out("ramp4");

        // D=4 negatives and signed zeros
        frm = new[16];
        frm[0]  = 32'hbf80_0000; frm[1]  = 32'hc000_0000; frm[2]  = 32'h0000_0000; frm[3]  = 32'h8000_0000;
        frm[4]  = 32'hbf00_0000; frm[5]  = 32'hc040_0000; frm[6]  = 32'h8000_0000; frm[7]  = 32'h8000_0000;
        frm[8]  = 32'h8000_0000; frm[9]  = 32'h0000_0000; frm[10] = 32'hc100_0000; frm[11] = 32'hbfc0_0000;
        frm[12] = 32'h0000_0000; frm[13] = 32'h0000_0000; frm[14] = 32'hc0a0_0000; frm[15] = 32'hc0e0_0000;
        run_frame(4, 4, 0);
        drain();
`ifdef MAXPOOL_RELU_EN
        chk("neg4_o0", got_v[0], 32'h0000_0000);
`else
        chk("neg4_o0", got_v[0], 32'hbf00_0000);
`endif
        chk("neg4_zero", got_v[1], 32'h0000_0000);
        check_out("neg4");

        // D=4 ramp with random gaps
        fill_ramp(4);
        run_frame(4, 4, 50);
        drain();
        chk("gap4_o3", got_v[3], 32'h4180_0000);
        check_out("gap4");

        // Reset after pixel 7, then a clean frame
        sel = 4;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus_v  = 1'b1;
            pxl_in = int2f(i + 1);
        end
        @(negedge clk);
        bus_v = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_o4", o4, 32'h0);
        chk("midrst_vo4", 32'(vo4), 32'h0);
        repeat (2) @(negedge clk);
        chk("midrst_o4_hold", o4, 32'h0);
        reset = 1'b1;
        got_v.delete(); got_t.delete();
        fill_ramp(4);
        run_frame(4, 4, 0);
        drain();
        chk("afterrst_o0", got_v[0], 32'h40c0_0000);
        check_out("afterrst");

        // D=5 ramp, two frames back to back
        fill_ramp(5);
        run_frame(5, 5, 0);
        run_frame(5, 5, 0);
        drain();
        chk("ramp5_o0", got_v[0], 32'h40e0_0000);
        chk("ramp5_o1", got_v[1], 32'h4110_0000);
        chk("ramp5_o2", got_v[2], 32'h4188_0000);
        chk("ramp5_o3", got_v[3], 32'h4198_0000);
        chk("ramp5_f2o0", got_v[4], 32'h40e0_0000);
        check_out("ramp5");

        // Random frames with gaps, including hold of pxl_out between pulses
        for (int f = 0; f < 3; f++) begin
            fill_rand(4);
            run_frame(4, 4, 30);
            drain();
            last = exp_v[exp_v.size() - 1];
            check_out($sformatf("rnd4_%0d", f));
            chk("hold4", o4, last);
        end
        for (int f = 0; f < 2; f++) begin
            fill_rand(5);
            run_frame(5, 5, 30);
            drain();
            check_out($sformatf("rnd5_%0d", f));
        end

        // Full-size frame
        fill_rand(149);
        run_frame(149, 149, 5);
        drain();
        check_out("rnd149");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout observed=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/maxpool_22_s2.md
MAXPOOL_22_S2 -- requirements
Module: maxpool_22_s2

Interface
REQ-001 SHALL have parameter D, default 149, input frame width and height in pixels (the square output of the 3x3/stride-2 conv on a 299x299 frame).
REQ-002 SHALL have parameter data_width, default 32, pixel width (IEEE-754 single).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port valid_in, input, 1, pxl_in carries a valid pixel this cycle.
REQ-006 SHALL have port pxl_in, input, data_width, raster-order pixel; connects to the conv stage's pxl_out.
REQ-007 SHALL have port pxl_out, output, data_width, 2x2 window maximum.
REQ-008 SHALL have port valid_out, output, 1, pxl_out valid; one-cycle pulse per window.

Function
REQ-009 SHALL apply 2x2 max pooling, stride 2, no padding, producing (D/2)x(D/2) outputs per frame (74x74 = 5476 for D=149), in raster order.
REQ-010 SHALL hold col (0..D-1) and row (0..D-1) counters, advanced only on valid_in=1; on col=D-1, col wraps to 0 and row increments; on row=D-1 and col=D-1, both wrap to 0 (next frame).
REQ-011 SHALL stall with all state held while valid_in=0; gaps of any length SHALL NOT change results.
REQ-012 SHALL, on even col, latch pxl_in into h_reg; on odd col, form hmax = max(h_reg, pxl_in).
REQ-013 SHALL use FSM states FILL (even row: write hmax into a line buffer of D/2 words at index col>>1), EMIT (odd row: produce max(buf[col>>1], hmax)), and SKIP (row D-1 when D is odd: consume pixels, emit nothing).
REQ-014 SHALL transition FILL->EMIT and EMIT->FILL at row wrap; EMIT->SKIP when the next row is D-1 and D is odd; SKIP->FILL at frame wrap.
REQ-015 SHALL ignore the final column (col=D-1) when D is odd: no h_reg update, no write, no emit.
REQ-016 SHALL register pxl_out/valid_out: valid_out=1 exactly on the cycle after the valid_in beat at (odd row, odd col), else 0; pxl_out holds its last value when valid_out=0.
REQ-017 SHALL compare floats by mapping each word to an ordered key (sign=0: set MSB; sign=1: invert all bits) and comparing keys unsigned; on equal keys the earlier operand wins; +0 and -0 are treated as equal. NaN inputs have undefined results.

Reset
REQ-018 SHALL, while reset=0, force col=0, row=0, state=FILL, h_reg=0, pxl_out=0, valid_out=0 immediately (asynchronous); line buffer contents need not be cleared.
REQ-019 SHALL, on reset asserted mid-frame, discard the partial frame; the first valid_in after deassertion is pixel (0,0).

Configuration
REQ-020 SHALL, when macro MAXPOOL_RELU_EN is defined, replace any pxl_in with sign bit 1 by 32'h00000000 before pooling (fused ReLU); without it, negative values pass through the compare unchanged.

Structure
REQ-021 SHALL take data_width, the default D, and float constants (zero, sign-bit position) from the shared conv package/header used by the conv stages.
REQ-022 SHALL implement the ordered compare as one combinational sub-module fp32_max (inputs a, b; output max), instantiated twice (horizontal, vertical).

Verification
REQ-023 D=4, continuous valid_in, pixels 1.0..16.0 raster (3f800000..41800000) -> 4 outputs 6.0, 8.0, 14.0, 16.0 (40c00000, 41000000, 41600000, 41800000), each 1 cycle after pixels 6, 8, 14, 16.
REQ-024 D=5, pixels 1.0..25.0 -> exactly 4 outputs 7.0, 9.0, 17.0, 19.0; column 4 and row 4 produce no valid_out; second frame repeats the identical sequence.
REQ-025 D=4, all pixels negative with window {-1.0, -2.0, -0.5, -3.0} -> bf000000 without MAXPOOL_RELU_EN, 00000000 with it; window {+0, -0} -> first operand 00000000.
REQ-026 D=4, valid_in toggled randomly 50% -> output values identical to REQ-023, valid_out count 4.
REQ-027 reset=0 asserted after pixel 7 of frame, released, then full frame 1.0..16.0 -> outputs as REQ-023; valid_out=0 and pxl_out=0 during reset.
REQ-028 D=149, stream conv stage output for 299x299 image -> exactly 5476 valid_out pulses per frame, matching a software 2x2 max-pool reference bit-exactly.
